// File: rtl/discus_spi_pkg.sv
// discus_spi_pkg: shared op codes, frame size and FSM state type
// for the discus SPI host.
package discus_spi_pkg;

  localparam logic [1:0] OP_ADDR   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_MREAD  = 2'b10;
  localparam logic [1:0] OP_MWRITE = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_tick.sv
// spi_tick: phase timer; reloads on phase entry and flags the
// last cycle of the phase.
module spi_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/discus_spi_host.sv
// discus_spi_host: 10-bit command-frame SPI initiator for the discus link.
// Define DISCUS_SPI_HOST_READBACK_EN to build the MISO read-back path.
module discus_spi_host
  import discus_spi_pkg::*;
#(
  parameter int SCK_DIV = 8,
  parameter int SS_GAP  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_ssel,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  state_t state;
  logic [3:0] edges;
  logic [FRAME_BITS-2:0] sh;
  logic accept;
  logic last;
  logic load;
  logic [CNT_W-1:0] len;

  assign accept = cmd_valid && cmd_ready;
  assign load   = (state == ST_IDLE) ? accept : last;
  assign len    = (state == ST_HOLD) ? CNT_W'(SS_GAP)
                                     : CNT_W'(SCK_DIV);

  spi_tick #(.W(CNT_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .len     (len),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      edges     <= '0;
      sh        <= '0;
      spi_sck   <= 1'b0;
      spi_ssel  <= 1'b1;
      spi_mosi  <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          state     <= ST_SETUP;
          sh        <= {cmd_op[0], cmd_data};
          edges     <= '0;
          spi_ssel  <= 1'b0;
          spi_mosi  <= cmd_op[1];
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
        end
        ST_SETUP, ST_LOW: if (last) begin
          state   <= ST_HIGH;
          spi_sck <= 1'b1;
          edges   <= edges + 4'd1;
        end
        ST_HIGH: if (last) begin
          spi_sck <= 1'b0;
          if (edges == 4'(FRAME_BITS)) begin
            state <= ST_HOLD;
          end else begin
            state    <= ST_LOW;
            spi_mosi <= sh[FRAME_BITS-2];
            sh       <= {sh[FRAME_BITS-3:0], 1'b0};
          end
        end
        ST_HOLD: if (last) begin
          state    <= ST_GAP;
          spi_ssel <= 1'b1;
          spi_mosi <= 1'b0;
        end
        ST_GAP: if (last) begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISCUS_SPI_HOST_READBACK_EN
  logic [1:0] miso_sync;
  logic [7:0] rx;
  logic rd_op;

  // Sample just before rising edges 3..10: the target's byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_sync <= '0;
      rx        <= '0;
      rd_op     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      miso_sync <= {miso_sync[0], spi_miso};
      rd_valid  <= 1'b0;
      if (accept) begin
        rd_op <= (cmd_op == OP_MREAD);
      end
      if (state == ST_LOW && last && edges >= 4'd2) begin
        rx <= {rx[6:0], miso_sync[1]};
      end
      if (state == ST_HOLD && last && rd_op) begin
        rd_valid <= 1'b1;
        rd_data  <= rx;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_discus_spi_host.sv
// tb_discus_spi_host: directed vector bench for discus_spi_host
// with a behavioural SPI target returning 0xC3.
module tb_discus_spi_host;

  localparam int SCK_DIV = 2;
  localparam int SS_GAP  = 4;
  localparam int FRAME_CYC = 21 * SCK_DIV + SS_GAP + 1;
`ifdef DISCUS_SPI_HOST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic spi_miso = 1'b0;
  logic cmd_ready, rd_valid, busy;
  logic spi_sck, spi_ssel, spi_mosi;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  discus_spi_host #(.SCK_DIV(SCK_DIV), .SS_GAP(SS_GAP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .spi_sck   (spi_sck),
    .spi_ssel  (spi_ssel),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Monitor and target model, sampled on the falling edge.
  int ncyc = 0, t_acc = 0, t_acc_prev = 0, t_fall = 0, t_rise = 0;
  int t_ready = 0, gap_hi = 0, ssel_low = 0, nbits = 0;
  int rd_pulses = 0, tgt_k = 0, glitch = 0;
  logic [9:0] mosi_bits = '0;
  logic [7:0] tgt_byte = 8'hC3;
  bit rd_at_rise = 1'b0;
  logic prev_sck = 1'b0, prev_ssel = 1'b1;
  logic prev_ready = 1'b1, prev_mosi = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (cmd_valid && cmd_ready) begin
      t_acc_prev = t_acc;
      t_acc = ncyc;
      nbits = 0;
      ssel_low = 0;
      rd_pulses = 0;
      rd_at_rise = 1'b0;
      mosi_bits = '0;
    end
    if (spi_sck && !prev_sck) begin
      mosi_bits = {mosi_bits[8:0], spi_mosi};
      nbits++;
      tgt_k++;
      if (tgt_k == 1) spi_miso = 1'b0;
      else if (tgt_k <= 9) spi_miso = tgt_byte[9 - tgt_k];
    end
    if (spi_ssel) begin
      tgt_k = 0;
      spi_miso = ~spi_miso;
    end
    if (!spi_ssel) ssel_low++;
    if (!spi_ssel && prev_ssel) begin
      t_fall = ncyc;
      gap_hi = ncyc - t_rise;
    end
    if (spi_ssel && !prev_ssel) t_rise = ncyc;
    if (cmd_ready && !prev_ready) t_ready = ncyc;
    if (rd_valid) begin
      rd_pulses++;
      rd_at_rise = spi_ssel && !prev_ssel;
    end
    if (spi_sck && prev_sck && spi_mosi !== prev_mosi) glitch++;
    prev_sck = spi_sck;
    prev_ssel = spi_ssel;
    prev_ready = cmd_ready;
    prev_mosi = spi_mosi;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (cmd_ready) break;
    end
    #1;
    chk(name, int'(cmd_ready), 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    @(posedge clk);
    #1;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    wait_ready("accept_wait");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [9:0] bits;
    int pulses;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 8'h5A, 10'b0001011010, 0, 8'h00};
    vecs[1] = '{2'b01, 8'h11, 10'b0100010001, 0, 8'h00};
    vecs[2] = '{2'b10, 8'hFF, 10'b1011111111, RB ? 1 : 0,
                RB ? 8'hC3 : 8'h00};
    vecs[3] = '{2'b11, 8'hA5, 10'b1110100101, 0,
                RB ? 8'hC3 : 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_held_ssel", int'(spi_ssel), 1);
    chk("rst_held_sck", int'(spi_sck), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sck", int'(spi_sck), 0);
    chk("rst_ssel", int'(spi_ssel), 1);
    chk("rst_mosi", int'(spi_mosi), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);

    for (int i = 0; i < 4; i++) begin
      send(vecs[i].op, vecs[i].data);
      wait_ready("frame_done");
      chk($sformatf("v%0d_mosi_bits", i), int'(mosi_bits),
          int'(vecs[i].bits));
      chk($sformatf("v%0d_edges", i), nbits, 10);
      chk($sformatf("v%0d_ssel_fall", i), t_fall - t_acc, 1);
      chk($sformatf("v%0d_ssel_low", i), ssel_low, 42);
      chk($sformatf("v%0d_ssel_rise", i), t_rise - t_acc, 43);
      chk($sformatf("v%0d_ready_back", i), t_ready - t_acc, 47);
      chk($sformatf("v%0d_rd_pulses", i), rd_pulses,
          vecs[i].pulses);
      chk($sformatf("v%0d_rd_at_rise", i), int'(rd_at_rise),
          vecs[i].pulses);
      chk($sformatf("v%0d_rd_data", i), int'(rd_data),
          int'(vecs[i].rd));
    end

    // Back-to-back: cmd_valid held across two commands.
    @(posedge clk);
    #1;
    cmd_op = 2'b01;
    cmd_data = 8'h11;
    cmd_valid = 1'b1;
    wait_ready("b2b_first");
    @(posedge clk);
    #1;
    cmd_op = 2'b11;
    cmd_data = 8'h22;
    wait_ready("b2b_second");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("b2b_spacing", t_acc - t_acc_prev, FRAME_CYC);
    wait_ready("b2b_done");
    chk("b2b_gap_ok", int'(gap_hi >= SS_GAP), 1);
    chk("b2b_mosi_bits", int'(mosi_bits), int'(10'b1100100010));
    chk("b2b_edges", nbits, 10);

    // Reset after the 5th rising edge of a read frame.
    @(posedge clk);
    #1;
    cmd_op = 2'b10;
    cmd_data = 8'h00;
    cmd_valid = 1'b1;
    wait_ready("mid_accept");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (nbits >= 5) break;
    end
    chk("mid_reach_edge5", nbits, 5);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_sck", int'(spi_sck), 0);
    chk("mid_ssel", int'(spi_ssel), 1);
    chk("mid_mosi", int'(spi_mosi), 0);
    chk("mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_ready_after", int'(cmd_ready), 1);
    chk("mid_no_rd_pulse", rd_pulses, 0);
    chk("mid_rd_data", int'(rd_data), 0);
    send(2'b00, 8'h3C);
    wait_ready("post_rst_done");
    chk("post_rst_edges", nbits, 10);
    chk("post_rst_bits", int'(mosi_bits), int'(10'b0000111100));
    chk("post_rst_ssel_low", ssel_low, 42);

    chk("mosi_stable_sck_high", glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/discus_spi_host.md
# discus_spi_host

SPI initiator for the discus software-interface link. It takes 10-bit command frames (2-bit op, 8-bit data) over a valid/ready port and serialises them on SCK/SSEL/MOSI to the discus SPI target. For memory-read frames it captures the returned byte from MISO. It sits in a loader/test harness that programs instruction RAM and reads back or writes data memory without a host MCU.

## Interface
Parameters:
- SCK_DIV, 8: `clk` cycles per SCK half-period; minimum 2. Must give at least 4 target-clock periods per half-period.
- SS_GAP, 16: `clk` cycles SSEL stays high between frames; minimum 2.

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 address, 01 program write, 10 memory read, 11 memory write
- cmd_data  in  8  data byte; don't-care for op 10
- rd_valid  out  1  one-cycle pulse, read byte available
- rd_data  out  8  last captured read byte; held until the next capture
- busy  out  1  high whenever not IDLE
- spi_sck  out  1  idles low
- spi_ssel  out  1  active-low; idles high
- spi_mosi  out  1  serial data, MSB first
- spi_miso  in  1  serial return; two-flop synchronised internally

## Operation
- All outputs are registered.
- Reset values: spi_sck 0, spi_ssel 1, spi_mosi 0, cmd_ready 1, busy 0, rd_valid 0, rd_data 0.
- Frame shift register (10 bits) = {op, data}, sent MSB first.
- States and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch the frame and go to SETUP.
  - SETUP: ssel=0, mosi=bit9; lasts SCK_DIV cycles, then HIGH.
  - HIGH: sck=1 for SCK_DIV cycles. After rising edges 1–9 go to LOW. After rising edge 10 go to HOLD.
  - LOW: sck=0 and mosi advances to the next bit on entry; lasts SCK_DIV cycles, then HIGH.
  - HOLD: sck=0, ssel=0 for SCK_DIV cycles. Then ssel=1 and go to GAP.
  - GAP: SS_GAP cycles, then IDLE.
- MISO capture: sample the synchronised MISO in the last cycle of the SETUP/LOW phase before rising edges 3..10. That gives 8 samples, MSB first. The target drives 0 after edge 1 and data bits after edges 2..9.
- rd_valid pulses in the cycle ssel goes high, only for op 10. rd_data updates in the same cycle.
- The target auto-increments its address after every frame except op 00. The host issues frames in any order; the block does no address tracking.
- cmd_valid while busy: ignored and not queued. The command stays pending until cmd_ready.
- Reset mid-frame: outputs return to idle values asynchronously and no rd_valid is generated. The target sees an SSEL rise and may commit a partial frame, so software must re-send an address frame after reset.

## Timing
- Accept at cycle T → spi_ssel falls at T+1.
- Rising edge k occurs at T+1+(2k−1)·SCK_DIV.
- spi_ssel rises at T+1+21·SCK_DIV.
- cmd_ready is high again at T+1+21·SCK_DIV+SS_GAP.
- Back-to-back throughput: one frame per 21·SCK_DIV+SS_GAP+1 cycles.
- MOSI changes only while sck is low, at least SCK_DIV cycles before each rising edge.
- MISO path latency: 2 synchroniser cycles, which is why SCK_DIV must be ≥2.

## Configuration
- DISCUS_SPI_HOST_READBACK_EN defined: MISO synchroniser, capture shifter, rd_valid and rd_data are implemented.
- Not defined: spi_miso is ignored, rd_valid is tied 0, rd_data is tied 0. Frame timing is identical in both builds.

## Structure
- Package discus_spi_pkg: op constants OP_ADDR=2'b00, OP_PROG=2'b01, OP_MREAD=2'b10, OP_MWRITE=2'b11; FRAME_BITS=10; state enum.
- Sub-module spi_tick: down-counter that reloads on phase entry and pulses on the last cycle of a phase (SCK_DIV or SS_GAP length). It is shared by all timed states.

## Test plan
- Reset held, then released → all outputs at reset values; cmd_ready 1 on the first cycle after release.
- SCK_DIV=2, SS_GAP=4, op 00 data 0x5A → MOSI at the 10 rising edges reads 0,0,0,1,0,1,1,0,1,0; ssel low for exactly 42 cycles; cmd_ready returns at T+47.
- Op 10 with a target model returning 0xC3 → exactly one rd_valid pulse, in the ssel-rise cycle, with rd_data=0xC3; no pulse for ops 00/01/11.
- cmd_valid held across two commands (01/0x11, then 11/0x22) → second accepted exactly 21·SCK_DIV+SS_GAP+1 cycles after the first; ssel high ≥ SS_GAP between frames.
- reset_n asserted after the 5th rising edge → same cycle: sck 0, ssel 1, mosi 0; no rd_valid; next command after release produces a complete 10-edge frame.
- Built without the macro, op 10 frame with MISO toggling → rd_valid never asserts, rd_data stays 0, frame timing unchanged.
